debug_uart_cmd_ctrl: RTL and testbench

Command controller that sits between debug_uart_receiver and the debug UART transmitter inside the debug UART path. It consumes received command bytes and selects one of eight 8-bit debug status words. It then drives the transmitter byte handshake for one of three responses: a single register read, a periodic stream of one register, or a framed dump of all eight registers with a checksum. It replaces ad-hoc register selection with a defined, testable command protocol.

---
 rtl/debug_uart_pkg.sv | 41 ++++
 rtl/debug_uart_cmd_fifo.sv | 28 ++
 rtl/debug_uart_cmd_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_debug_uart_cmd_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_uart_pkg.sv
// Shared constants for the debug UART command controller: state codes, opcodes,
// register indices and the frame checksum helper.
package debug_uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_DECODE    = 3'd1;
    localparam state_t ST_LOAD      = 3'd2;
    localparam state_t ST_SEND      = 3'd3;
    localparam state_t ST_WAIT_DONE = 3'd4;

    localparam logic [3:0] OP_READ   = 4'h0;
    localparam logic [3:0] OP_STREAM = 4'h1;
    localparam logic [3:0] OP_STOP   = 4'h2;
    localparam logic [3:0] OP_DUMP   = 4'h3;

    localparam int NUM_REGS = 8;

    localparam logic [2:0] IDX_MAIN      = 3'd0;
    localparam logic [2:0] IDX_CAN       = 3'd1;
    localparam logic [2:0] IDX_CAN_MUX   = 3'd2;
    localparam logic [2:0] IDX_OSC_TRIM  = 3'd3;
    localparam logic [2:0] IDX_ELINK_TRA = 3'd4;
    localparam logic [2:0] IDX_ELINK_REC = 3'd5;
    localparam logic [2:0] IDX_SPI       = 3'd6;
    localparam logic [2:0] IDX_DEC10B    = 3'd7;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;
    localparam logic [7:0] ERR_DEFAULT = 8'hEE;

    function automatic logic [7:0] xor_bytes(input logic [63:0] words);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            acc = acc ^ words[8*i +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/debug_uart_cmd_fifo.sv
// One-deep pending command buffer; a write while full (and not being popped)
// is dropped and flagged as overrun in the same cycle.
module debug_uart_cmd_fifo (
    input  logic       clk_uart,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] wr_byte,
    input  logic       pop,
    output logic       valid,
    output logic [7:0] rd_byte,
    output logic       overrun
);

    assign overrun = wr && valid && !pop;

    always_ff @(posedge clk_uart or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            rd_byte <= '0;
        end else if (wr && (!valid || pop)) begin
            valid   <= 1'b1;
            rd_byte <= wr_byte;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/debug_uart_cmd_ctrl.sv
// Debug UART command controller: decodes command bytes and drives the
// transmitter handshake for single reads, periodic streaming and framed dumps.
//
// state      | meaning
// IDLE       | waiting for a pending command or a stream tick
// DECODE     | pop command / sample status, set up the response
// LOAD       | present the next response byte on out_tx_byte
// SEND       | wait for transmitter idle, pulse out_tx_dv
// WAIT_DONE  | wait for in_tx_done, with timeout
module debug_uart_cmd_ctrl
    import debug_uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT  = 87,
    parameter int         STREAM_PERIOD = 16384,
    parameter logic [7:0] HDR_BYTE      = HDR_DEFAULT,
    parameter logic [7:0] ERR_BYTE      = ERR_DEFAULT
) (
    input  logic        clk_uart,
    input  logic        rst,
    input  logic        in_rx_dv,
    input  logic [7:0]  in_rx_byte,
    input  logic [63:0] in_status_vec,
    output logic        out_tx_dv,
    output logic [7:0]  out_tx_byte,
    input  logic        in_tx_active,
    input  logic        in_tx_done,
    output logic [7:0]  out_register_status,
    output logic        out_busy,
    output logic        out_cmd_err,
    output logic        out_overrun,
    output logic        out_streaming
);

    localparam int TMO_CYCLES = 12 * CLKS_PER_BIT;
    localparam int TW = $clog2(TMO_CYCLES);
    localparam int PW = $clog2(STREAM_PERIOD);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TMO_CYCLES - 1);
    localparam logic [PW-1:0] PER_LOAD = PW'(STREAM_PERIOD - 1);

    state_t        state;
    logic          fifo_wr, fifo_pop, fifo_valid;
    logic [7:0]    fifo_byte;
    logic          stop_cmd, illegal, start_stream, tick;
    logic [3:0]    op, idx;
    logic          streaming, tick_pending, src_tick, dump_mode, resp_is_data;
    logic [2:0]    stream_idx, dump_idx;
    logic [7:0]    resp_byte, load_byte;
    logic          load_is_data;
    logic [3:0]    bytes_left;
    logic [63:0]   frame;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] tmo_cnt;

    // Stop never queues behind other commands so it can cut a stream at once.
    assign stop_cmd     = in_rx_dv && (in_rx_byte[7:4] == OP_STOP);
    assign fifo_wr      = in_rx_dv && !stop_cmd;
    assign fifo_pop     = (state == ST_DECODE) && !src_tick;
    assign op           = fifo_byte[7:4];
    assign idx          = fifo_byte[3:0];
    assign illegal      = !(op == OP_READ || op == OP_STREAM || op == OP_DUMP) ||
                          (op != OP_DUMP && idx[3]);
    assign start_stream = fifo_pop && !illegal && (op == OP_STREAM);
    assign tick         = streaming && (period_cnt == '0);
    assign dump_idx     = 3'(4'd9 - bytes_left);

    assign out_busy      = (state != ST_IDLE);
    assign out_streaming = streaming;

    debug_uart_cmd_fifo u_fifo (
        .clk_uart (clk_uart),
        .rst      (rst),
        .wr       (fifo_wr),
        .wr_byte  (in_rx_byte),
        .pop      (fifo_pop),
        .valid    (fifo_valid),
        .rd_byte  (fifo_byte),
        .overrun  (out_overrun)
    );

    // Dump frame: bytes_left 10 is the header, 9..2 the registers, 1 the checksum.
    always_comb begin
        load_byte    = resp_byte;
        load_is_data = resp_is_data;
        if (dump_mode) begin
            if (bytes_left == 4'd10) begin
                load_byte    = HDR_BYTE;
                load_is_data = 1'b0;
            end else if (bytes_left == 4'd1) begin
                load_byte    = xor_bytes(frame);
                load_is_data = 1'b0;
            end else begin
                load_byte    = frame[{dump_idx, 3'b000} +: 8];
                load_is_data = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_uart or posedge rst) begin
        if (rst) begin
            streaming    <= 1'b0;
            tick_pending <= 1'b0;
            stream_idx   <= '0;
            period_cnt   <= '0;
        end else begin
            if (start_stream)
                period_cnt <= PER_LOAD;
            else if (streaming)
                period_cnt <= tick ? PER_LOAD : period_cnt - 1'b1;

            if (stop_cmd)
                streaming <= 1'b0;
            else if (start_stream)
                streaming <= 1'b1;

            if (start_stream)
                stream_idx <= idx[2:0];

            if (stop_cmd || start_stream)
                tick_pending <= 1'b0;
            else if (tick)
                tick_pending <= 1'b1;
            else if (state == ST_DECODE && src_tick)
                tick_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk_uart or posedge rst) begin
        if (rst) begin
            state               <= ST_IDLE;
            src_tick            <= 1'b0;
            dump_mode           <= 1'b0;
            resp_is_data        <= 1'b0;
            resp_byte           <= '0;
            bytes_left          <= '0;
            frame               <= '0;
            tmo_cnt             <= '0;
            out_tx_dv           <= 1'b0;
            out_tx_byte         <= '0;
            out_register_status <= '0;
            out_cmd_err         <= 1'b0;
        end else begin
            out_tx_dv   <= 1'b0;
            out_cmd_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fifo_valid || fifo_wr) begin
                        src_tick <= 1'b0;
                        state    <= ST_DECODE;
                    end else if (tick_pending) begin
                        src_tick <= 1'b1;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    dump_mode    <= 1'b0;
                    bytes_left   <= 4'd1;
                    resp_is_data <= 1'b1;
                    state        <= ST_LOAD;
                    if (src_tick) begin
                        resp_byte <= in_status_vec[{stream_idx, 3'b000} +: 8];
                    end else if (illegal) begin
                        resp_byte    <= ERR_BYTE;
                        resp_is_data <= 1'b0;
                        out_cmd_err  <= 1'b1;
                    end else if (op == OP_DUMP) begin
                        frame      <= in_status_vec;
                        dump_mode  <= 1'b1;
                        bytes_left <= 4'd10;
                    end else begin
                        resp_byte <= in_status_vec[{idx[2:0], 3'b000} +: 8];
                    end
                end
                ST_LOAD: begin
                    out_tx_byte <= load_byte;
                    if (load_is_data)
                        out_register_status <= load_byte;
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (!in_tx_active) begin
                        out_tx_dv <= 1'b1;
                        tmo_cnt   <= TMO_LOAD;
                        state     <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (in_tx_done) begin
                        bytes_left <= bytes_left - 1'b1;
                        state      <= (bytes_left > 4'd1) ? ST_LOAD : ST_IDLE;
                    end else if (tmo_cnt == '0) begin
                        out_cmd_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_uart_cmd_ctrl.sv
// Scoreboard bench for debug_uart_cmd_ctrl: a reference model queues expected
// transmit bytes per command, a monitor pops and compares on every out_tx_dv.
module tb_debug_uart_cmd_ctrl;

    localparam int CPB = 87;
    localparam int SP  = 64;

    logic        clk_uart = 1'b0;
    logic        rst = 1'b1;
    logic        in_rx_dv = 1'b0;
    logic [7:0]  in_rx_byte = '0;
    logic [63:0] in_status_vec = '0;
    logic        out_tx_dv;
    logic [7:0]  out_tx_byte;
    logic        in_tx_active = 1'b0;
    logic        in_tx_done = 1'b0;
    logic [7:0]  out_register_status;
    logic        out_busy, out_cmd_err, out_overrun, out_streaming;

    debug_uart_cmd_ctrl #(
        .CLKS_PER_BIT  (CPB),
        .STREAM_PERIOD (SP),
        .HDR_BYTE      (8'hA5),
        .ERR_BYTE      (8'hEE)
    ) dut (
        .clk_uart            (clk_uart),
        .rst                 (rst),
        .in_rx_dv            (in_rx_dv),
        .in_rx_byte          (in_rx_byte),
        .in_status_vec       (in_status_vec),
        .out_tx_dv           (out_tx_dv),
        .out_tx_byte         (out_tx_byte),
        .in_tx_active        (in_tx_active),
        .in_tx_done          (in_tx_done),
        .out_register_status (out_register_status),
        .out_busy            (out_busy),
        .out_cmd_err         (out_cmd_err),
        .out_overrun         (out_overrun),
        .out_streaming       (out_streaming)
    );

    always #5 clk_uart = ~clk_uart;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int tx_seen = 0, last_tx_cyc = 0, err_seen = 0, err_cyc = 0, ovr_seen = 0;
    int exp_err = 0, exp_ovr = 0;
    logic [7:0] exp_reg = '0;
    bit done_en = 1'b1;

    always @(posedge clk_uart) cyc <= cyc + 1;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every transmitted byte against the scoreboard.
    always @(negedge clk_uart) begin
        if (!rst) begin
            if (out_tx_dv) begin
                tx_seen++;
                last_tx_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %02h expected none", out_tx_byte);
                end else begin
                    check8("tx_byte", out_tx_byte, exp_q.pop_front());
                end
            end
            if (out_cmd_err) begin
                err_seen++;
                err_cyc = cyc;
            end
            if (out_overrun) ovr_seen++;
        end
    end

    // Transmitter model: busy for a few cycles, then a done strobe if enabled.
    initial forever begin
        bit give;
        @(negedge clk_uart);
        if (out_tx_dv && !rst) begin
            give = done_en;
            in_tx_active = 1'b1;
            repeat (5) @(negedge clk_uart);
            in_tx_active = 1'b0;
            if (give) begin
                in_tx_done = 1'b1;
                @(negedge clk_uart);
                in_tx_done = 1'b0;
            end
        end
    end

    function automatic logic [7:0] reg_of(input int i);
        return in_status_vec[8*i +: 8];
    endfunction

    // Reference model: expected transmit bytes for one buffered command.
    task automatic push_cmd(input logic [7:0] b);
        int op;
        int ix;
        logic [7:0] x;
        op = int'(b[7:4]);
        ix = int'(b[3:0]);
        if ((op == 0 || op == 1) && ix < 8) begin
            exp_q.push_back(reg_of(ix));
            exp_reg = reg_of(ix);
        end else if (op == 3) begin
            x = 8'h00;
            exp_q.push_back(8'hA5);
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back(reg_of(i));
                x = x ^ reg_of(i);
            end
            exp_q.push_back(x);
            exp_reg = reg_of(7);
        end else begin
            exp_q.push_back(8'hEE);
            exp_err++;
        end
    endtask

    task automatic send_cmd(input logic [7:0] b, output int drive_cyc);
        @(negedge clk_uart);
        in_rx_dv = 1'b1;
        in_rx_byte = b;
        drive_cyc = cyc;
        @(negedge clk_uart);
        in_rx_dv = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((out_busy || exp_q.size() != 0 || in_tx_active || in_tx_done) && n < budget) begin
            @(negedge clk_uart);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
        end
        repeat (2) @(negedge clk_uart);
    endtask

    task automatic wait_tx(input string name, input int prev, input int budget);
        int n;
        n = 0;
        while (tx_seen <= prev && n < budget) begin
            @(negedge clk_uart);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: no tx after %0d cycles, expected one", name, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_tx_dv"}, out_tx_dv, 1'b0);
        check8({tag, "_tx_byte"}, out_tx_byte, 8'h00);
        check8({tag, "_reg_status"}, out_register_status, 8'h00);
        check1({tag, "_busy"}, out_busy, 1'b0);
        check1({tag, "_cmd_err"}, out_cmd_err, 1'b0);
        check1({tag, "_overrun"}, out_overrun, 1'b0);
        check1({tag, "_streaming"}, out_streaming, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int n;
        int prev;
        int t[5];
        logic [7:0] b;

        repeat (3) @(negedge clk_uart);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk_uart);

        // Serial single reads of all indices, with idle-path latency.
        in_status_vec = {8'h1B, 8'h1A, 8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
        for (int i = 0; i < 8; i++) begin
            push_cmd(8'(i));
            send_cmd(8'(i), dc);
            wait_idle("read", 200);
            if (i == 0) checki("read_latency", last_tx_cyc - dc, 4);
        end
        check8("read_reg_status", out_register_status, exp_reg);
        checki("read_no_err", err_seen, exp_err);

        // Full dump frame.
        push_cmd(8'h30);
        send_cmd(8'h30, dc);
        wait_idle("dump", 400);
        check8("dump_reg_status", out_register_status, exp_reg);

        // Illegal index and illegal opcode.
        push_cmd(8'h09);
        send_cmd(8'h09, dc);
        wait_idle("illegal_idx", 200);
        push_cmd(8'h50);
        send_cmd(8'h50, dc);
        wait_idle("illegal_op", 200);
        checki("illegal_err_count", err_seen, exp_err);
        check8("illegal_reg_status", out_register_status, exp_reg);

        // Randomized reads, dumps and illegal bytes.
        for (int k = 0; k < 16; k++) begin
            in_status_vec = {$urandom, $urandom};
            b = 8'($urandom_range(0, 255));
            if (b[7:4] == 4'h1 || b[7:4] == 4'h2) b[7:4] = 4'h0;
            push_cmd(b);
            send_cmd(b, dc);
            wait_idle("random", 400);
            check8("random_reg_status", out_register_status, exp_reg);
        end
        checki("random_err_count", err_seen, exp_err);

        // Stream index 2 with a live, incrementing value.
        in_status_vec[23:16] = 8'h40;
        push_cmd(8'h12);
        prev = tx_seen;
        send_cmd(8'h12, dc);
        for (int k = 0; k < 5; k++) begin
            wait_tx("stream", prev, 200);
            prev = tx_seen;
            t[k] = last_tx_cyc;
            in_status_vec[23:16] = in_status_vec[23:16] + 8'h01;
            if (k < 4) push_cmd(8'h02);
            if (k == 0) check1("stream_flag_on", out_streaming, 1'b1);
        end
        for (int k = 2; k < 5; k++) checki("stream_period", t[k] - t[k-1], SP);
        repeat (12) @(negedge clk_uart);
        send_cmd(8'h20, dc);
        check1("stream_flag_off", out_streaming, 1'b0);
        repeat (3 * SP) @(negedge clk_uart);
        checki("stream_no_extra", tx_seen, prev);
        check8("stream_reg_status", out_register_status, exp_reg);

        // Back-to-back commands during a dump: one buffered, two dropped.
        in_status_vec = {$urandom, $urandom};
        push_cmd(8'h30);
        prev = tx_seen;
        send_cmd(8'h30, dc);
        wait_tx("dump2", prev, 100);
        push_cmd(8'h00);
        @(negedge clk_uart);
        in_rx_dv = 1'b1;
        in_rx_byte = 8'h00;
        @(negedge clk_uart);
        in_rx_byte = 8'h01;
        @(negedge clk_uart);
        in_rx_byte = 8'h02;
        @(negedge clk_uart);
        in_rx_dv = 1'b0;
        exp_ovr += 2;
        wait_idle("overrun", 600);
        checki("overrun_count", ovr_seen, exp_ovr);
        check8("overrun_reg_status", out_register_status, exp_reg);

        // Transmitter never finishes: timeout after 12 bit periods.
        done_en = 1'b0;
        push_cmd(8'h05);
        prev = tx_seen;
        send_cmd(8'h05, dc);
        wait_tx("tmo_tx", prev, 100);
        prev = err_seen;
        n = 0;
        while (err_seen == prev && n < 1300) begin
            @(negedge clk_uart);
            n++;
        end
        exp_err++;
        checki("timeout_err_count", err_seen, exp_err);
        checki("timeout_delay", err_cyc - last_tx_cyc, 12 * CPB);

        // Reset while waiting for done, then a normal command.
        push_cmd(8'h06);
        prev = tx_seen;
        send_cmd(8'h06, dc);
        wait_tx("rst_tx", prev, 100);
        repeat (20) @(negedge clk_uart);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk_uart);
        rst = 1'b0;
        exp_reg = 8'h00;
        done_en = 1'b1;
        repeat (10) @(negedge clk_uart);
        push_cmd(8'h04);
        send_cmd(8'h04, dc);
        wait_idle("post_rst", 200);
        check8("post_rst_reg_status", out_register_status, exp_reg);
        checki("final_err_count", err_seen, exp_err);
        checki("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
